// File: rtl/pixel_denormalizer.sv
// Pixel denormalizer: clamps signed fixed-point activations to [0,1]
// and rescales them to 8-bit pixels, with frame tagging and clip counters.
// Ports: clk, rst (sync, active-high)
//   s_valid/s_ready/s_data : fixed-point sample input
//   m_valid/m_ready/m_data/m_last : pixel output, m_last on final pixel
//   sat_hi_cnt/sat_lo_cnt : sticky saturating counts of clipped inputs
module pixel_denormalizer #(
  parameter int IN_W         = 16,
  parameter int FRAC_BITS    = 8,
  parameter int FRAME_PIXELS = 784,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] sat_hi_cnt,
  output logic [CNT_W-1:0] sat_lo_cnt
);

  localparam int IDX_W = $clog2(FRAME_PIXELS);
  localparam int PW    = FRAC_BITS + 8;

  localparam logic [IN_W-1:0]  ONE  = IN_W'(1) << FRAC_BITS;
  localparam logic [PW-1:0]    HALF = PW'(1) << (FRAC_BITS - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_PIXELS - 1);

  logic             en;
  logic             xfer;
  logic             lo_n;
  logic             hi_n;
  logic [PW-1:0]    s_lo;
  logic [PW-1:0]    prod_n;
  logic [7:0]       pix;

  logic             v1;
  logic             lo1;
  logic             hi1;
  logic             last1;
  logic [PW-1:0]    prod1;
  logic [IDX_W-1:0] idx;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign xfer    = s_valid && en;

  assign lo_n = s_data[IN_W-1];
  assign hi_n = !lo_n && (s_data > ONE);

  // In-range values are <= ONE, so x*255 fits in
  // FRAC_BITS+8 bits; only the low bits are kept.
  assign s_lo   = PW'(s_data);
  assign prod_n = (s_lo << 8) - s_lo;

  always_comb begin
    pix = 8'd0;
    unique case (1'b1)
      lo1:     pix = 8'd0;
      hi1:     pix = 8'd255;
      default: pix = 8'((prod1 + HALF) >> FRAC_BITS);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      lo1        <= 1'b0;
      hi1        <= 1'b0;
      last1      <= 1'b0;
      prod1      <= '0;
      idx        <= '0;
      m_valid    <= 1'b0;
      m_data     <= 8'd0;
      m_last     <= 1'b0;
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else begin
      if (en) begin
        v1      <= s_valid;
        m_valid <= v1;
        if (s_valid) begin
          lo1   <= lo_n;
          hi1   <= hi_n;
          prod1 <= prod_n;
          last1 <= (idx == LAST);
        end
        if (v1) begin
          m_data <= pix;
          m_last <= last1;
        end
      end
      if (xfer) begin
        idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
        if (hi_n && sat_hi_cnt != '1)
          sat_hi_cnt <= sat_hi_cnt + CNT_W'(1);
        if (lo_n && sat_lo_cnt != '1)
          sat_lo_cnt <= sat_lo_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_denormalizer.sv
// Self-checking bench for pixel_denormalizer against a
// queue-based arithmetic reference model.
module tb_pixel_denormalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] sat_hi_cnt;
  logic [15:0] sat_lo_cnt;

  pixel_denormalizer dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .sat_hi_cnt (sat_hi_cnt),
    .sat_lo_cnt (sat_lo_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int q_data[$];
  bit q_last[$];
  int q_cyc[$];
  int m_idx = 0;
  int m_hi = 0;
  int m_lo = 0;
  int n_in = 0;
  int cyc = 0;
  int nlast = 0;
  bit chk_lat = 1'b0;

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pix(logic [15:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) return 0;
    if (v > 256) return 255;
    return (v * 255 + 128) / 256;
  endfunction

  task automatic tick(bit v, logic [15:0] d, bit r);
    int lat;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (q_data.size() == 0) begin
        check("spurious", 1, 0);
      end else begin
        check("data", int'(m_data), q_data.pop_front());
        check("last", int'(m_last), int'(q_last.pop_front()));
        lat = cyc - q_cyc.pop_front();
        if (chk_lat) check("latency", lat, 2);
        if (m_last) nlast++;
      end
    end
    if (s_valid && s_ready) begin
      q_data.push_back(ref_pix(d));
      q_last.push_back(m_idx == 783);
      q_cyc.push_back(cyc);
      m_idx = (m_idx + 1) % 784;
      if (int'($signed(d)) < 0 && m_lo < 65535) m_lo++;
      if (int'($signed(d)) > 256 && m_hi < 65535) m_hi++;
      n_in++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0, 1'b1);
    check("drained", q_data.size(), 0);
    check("sat_hi", int'(sat_hi_cnt), m_hi);
    check("sat_lo", int'(sat_lo_cnt), m_lo);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    m_idx = 0;
    m_hi  = 0;
    m_lo  = 0;
  endtask

  logic [15:0] t1[5] = '{16'h0000, 16'h0040, 16'h0080,
                         16'h00C0, 16'h0100};
  logic [15:0] t2[4] = '{16'hFF00, 16'h8000, 16'h0101,
                         16'h7FFF};

  initial begin
    int gaps;
    int held;
    int tgt;
    s_data = 16'h0;
    do_reset();
    @(negedge clk);
    check("rst_mvalid", int'(m_valid), 0);
    check("rst_mdata", int'(m_data), 0);
    check("rst_mlast", int'(m_last), 0);
    check("rst_hi", int'(sat_hi_cnt), 0);
    check("rst_lo", int'(sat_lo_cnt), 0);
    @(posedge clk);
    #1;

    chk_lat = 1'b1;
    foreach (t1[i]) tick(1'b1, t1[i], 1'b1);
    drain();
    foreach (t2[i]) tick(1'b1, t2[i], 1'b1);
    drain();
    chk_lat = 1'b0;
    check("t2_lo", int'(sat_lo_cnt), 2);
    check("t2_hi", int'(sat_hi_cnt), 2);

    do_reset();
    nlast = 0;
    gaps  = 0;
    for (int i = 0; i < 1570; i++) begin
      tick(1'b1, 16'($urandom_range(0, 300)), 1'b1);
      if (i >= 1 && !m_valid) gaps++;
    end
    drain();
    check("gaps", gaps, 0);
    check("nlast", nlast, 2);

    for (int i = 0; i < 10; i++)
      tick(1'b1, 16'($urandom), 1'b1);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'($urandom), 1'b0);
      if (i == 0) held = int'(m_data);
      check("hold_valid", int'(m_valid), 1);
      check("hold_data", int'(m_data), held);
      check("hold_sready", int'(s_ready), 0);
    end
    drain();

    tgt = n_in + 5000;
    for (int i = 0; i < 40000 && n_in < tgt; i++)
      tick(1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)));
    check("rand_count", n_in, tgt);
    drain();

    tick(1'b1, 16'hFF00, 1'b1);
    tick(1'b1, 16'h0200, 1'b1);
    do_reset();
    @(negedge clk);
    check("rst2_mvalid", int'(m_valid), 0);
    check("rst2_hi", int'(sat_hi_cnt), 0);
    check("rst2_lo", int'(sat_lo_cnt), 0);
    @(posedge clk);
    #1;
    nlast = 0;
    tick(1'b1, 16'h0080, 1'b1);
    tick(1'b1, 16'h0040, 1'b1);
    tick(1'b1, 16'h0100, 1'b1);
    drain();
    check("rst2_nlast", nlast, 0);
    check("rst2_idx", m_idx, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
